// File: rtl/flash_read_scheduler.sv
// Sequences one flash read per address FIFO entry: pop, launch SPI read, present byte, hold.
// Optional WAIT watchdog is compiled in with `define SCHED_TIMEOUT_EN.
module flash_read_scheduler #(
    parameter int unsigned HOLD_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_rd_data,
    input  logic       spi_busy,
    output logic       spi_start,
    output logic [7:0] spi_addr,
    input  logic       spi_done,
    input  logic [7:0] spi_data,
    input  logic       pause,
    output logic [7:0] disp_data,
    output logic       disp_valid,
    output logic       busy,
    output logic [7:0] rd_count,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StFetch,
        StLaunch,
        StWait,
        StHold
    } state_e;

    // A zero hold length still spends one clock in HOLD.
    localparam int unsigned HoldLast = (HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1;

    state_e      state_q, state_d;
    logic        fifo_rd_en_q, fifo_rd_en_d;
    logic        spi_start_q, spi_start_d;
    logic [7:0]  spi_addr_q, spi_addr_d;
    logic [7:0]  disp_data_q, disp_data_d;
    logic        disp_valid_q, disp_valid_d;
    logic        busy_q, busy_d;
    logic [7:0]  rd_count_q, rd_count_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned TimeoutLast = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        err_timeout_q, err_timeout_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            fifo_rd_en_q <= 1'b0;
            spi_start_q  <= 1'b0;
            spi_addr_q   <= 8'h00;
            disp_data_q  <= 8'h00;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            rd_count_q   <= 8'h00;
            hold_cnt_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            spi_start_q  <= spi_start_d;
            spi_addr_q   <= spi_addr_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            busy_q       <= busy_d;
            rd_count_q   <= rd_count_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q      <= 32'd0;
            err_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end
`endif

    // Pulse outputs are set on the transition edge so they are high for the state's cycle.
    always_comb begin
        state_d       = state_q;
        fifo_rd_en_d  = 1'b0;
        spi_start_d   = 1'b0;
        spi_addr_d    = spi_addr_q;
        disp_data_d   = disp_data_q;
        disp_valid_d  = 1'b0;
        rd_count_d    = rd_count_q;
        hold_cnt_d    = hold_cnt_q;
`ifdef SCHED_TIMEOUT_EN
        wd_cnt_d      = wd_cnt_q;
        err_timeout_d = err_timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !pause) begin
                    state_d      = StPop;
                    fifo_rd_en_d = 1'b1;
                end
            end
            StPop: begin
                state_d = StFetch;
            end
            StFetch: begin
                spi_addr_d = fifo_rd_data;
                state_d    = StLaunch;
            end
            StLaunch: begin
                if (!spi_busy) begin
                    spi_start_d = 1'b1;
                    state_d     = StWait;
`ifdef SCHED_TIMEOUT_EN
                    wd_cnt_d    = 32'd0;
`endif
                end
            end
            StWait: begin
                // A completion on the final watchdog cycle takes priority over the timeout.
                if (spi_done) begin
                    disp_data_d   = spi_data;
                    disp_valid_d  = 1'b1;
                    rd_count_d    = rd_count_q + 8'd1;
                    hold_cnt_d    = 32'd0;
                    state_d       = StHold;
                end
`ifdef SCHED_TIMEOUT_EN
                else if (wd_cnt_q == TimeoutLast) begin
                    err_timeout_d = 1'b1;
                    disp_data_d   = 8'h3F;
                    disp_valid_d  = 1'b1;
                    hold_cnt_d    = 32'd0;
                    state_d       = StHold;
                end else begin
                    wd_cnt_d      = wd_cnt_q + 32'd1;
                end
`endif
            end
            StHold: begin
                if (hold_cnt_q == HoldLast) begin
                    state_d = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    assign fifo_rd_en = fifo_rd_en_q;
    assign spi_start  = spi_start_q;
    assign spi_addr   = spi_addr_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign busy       = busy_q;
    assign rd_count   = rd_count_q;
`ifdef SCHED_TIMEOUT_EN
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_flash_read_scheduler.sv
// Scoreboard bench for flash_read_scheduler: FIFO and SPI engine models feed an expected-result
// queue that a negedge monitor drains against disp_valid.
module tb_flash_read_scheduler;

    localparam int unsigned Hold = 4;
    localparam int unsigned Tmo  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       spi_busy;
    logic       spi_start;
    logic [7:0] spi_addr;
    logic       spi_done;
    logic [7:0] spi_data;
    logic       pause;
    logic [7:0] disp_data;
    logic       disp_valid;
    logic       busy;
    logic [7:0] rd_count;
    logic       err_timeout;

    flash_read_scheduler #(
        .HOLD_CYCLES   (Hold),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .spi_busy    (spi_busy),
        .spi_start   (spi_start),
        .spi_addr    (spi_addr),
        .spi_done    (spi_done),
        .spi_data    (spi_data),
        .pause       (pause),
        .disp_data   (disp_data),
        .disp_valid  (disp_valid),
        .busy        (busy),
        .rd_count    (rd_count),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] count;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] addr_q[$];
    logic [7:0] mem[0:1023];
    int         push_idx = 0;
    int         pop_idx = 0;

    assign fifo_empty = (push_idx == pop_idx);

    int         errors = 0;
    int         checks = 0;
    int         start_cnt = 0;
    int         pop_cnt = 0;
    int         valid_cnt = 0;
    int         cyc = 0;
    int         pop_cyc = 0;
    bit         busy_seen = 0;
    bit         pend = 0;
    int         cnt = 0;
    int         resp_mode = 0;   // 0: engine answers, 1: engine never answers
    int         resp_delay = -1; // <0: random 0..3 cycles
    bit         done_by_mon = 0;
    logic [7:0] model_count = 8'h00;
    bit         model_err = 0;
    bit         hold_run = 0;
    int         hold_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a);
        mem[push_idx] = a;
        push_idx++;
    endtask

    task automatic wait_valid(input int target, input int budget, input string name);
        int k = 0;
        while (valid_cnt < target && k < budget) begin
            tick(1);
            k++;
        end
        check(name, 32'(valid_cnt >= target), 32'd1);
    endtask

    task automatic wait_start(input int target, input int budget, input string name);
        int k = 0;
        while (start_cnt < target && k < budget) begin
            tick(1);
            k++;
        end
        check(name, 32'(start_cnt >= target), 32'd1);
    endtask

    task automatic clear_model();
        exp_q.delete();
        addr_q.delete();
        pend        = 0;
        done_by_mon = 0;
        spi_done    = 1'b0;
        model_count = 8'h00;
        model_err   = 0;
        hold_run    = 0;
        start_cnt   = 0;
        pop_cnt     = 0;
        pop_idx     = push_idx;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (done_by_mon) begin
                spi_done    = 1'b0;
                done_by_mon = 0;
            end
            if (!rst) continue;
            if (spi_busy) busy_seen = 1;
            // FIFO model: pop data is presented from mid-POP and held through FETCH.
            if (fifo_rd_en) begin
                check("pop_while_empty", 32'(fifo_empty), 32'd0);
                check("one_pop_per_txn", 32'(pop_cnt - start_cnt), 32'd0);
                if (!fifo_empty) begin
                    fifo_rd_data = mem[pop_idx];
                    addr_q.push_back(mem[pop_idx]);
                    pop_idx++;
                end
                pop_cnt++;
                pop_cyc   = cyc;
                busy_seen = spi_busy;
            end
            // SPI engine model.
            if (spi_start) begin
                start_cnt++;
                if (!busy_seen) check("start_latency", 32'(cyc - pop_cyc), 32'd3);
                if (addr_q.size() == 0) check("start_without_pop", 32'd1, 32'd0);
                else check("spi_addr", {24'd0, spi_addr}, {24'd0, addr_q.pop_front()});
                if (resp_mode == 0) begin
                    pend = 1;
                    cnt  = (resp_delay < 0) ? int'($urandom_range(0, 3)) : resp_delay;
                end else begin
`ifdef SCHED_TIMEOUT_EN
                    e.data    = 8'h3F;
                    e.count   = model_count;
                    e.err     = 1'b1;
                    model_err = 1;
                    exp_q.push_back(e);
`endif
                end
            end
            if (pend) begin
                if (cnt == 0) begin
                    spi_data    = 8'($urandom);
                    spi_done    = 1'b1;
                    done_by_mon = 1;
                    model_count = model_count + 8'd1;
                    e.data      = spi_data;
                    e.count     = model_count;
                    e.err       = model_err;
                    exp_q.push_back(e);
                    pend        = 0;
                end else begin
                    cnt--;
                end
            end
            if (hold_run) begin
                if (busy) hold_len++;
                else begin
                    check("hold_len", 32'(hold_len), Hold);
                    hold_run = 0;
                end
            end
            if (disp_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) check("unexpected_disp_valid", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("disp_data", {24'd0, disp_data}, {24'd0, e.data});
                    check("rd_count", {24'd0, rd_count}, {24'd0, e.count});
                    check("err_timeout", 32'(err_timeout), 32'(e.err));
                end
                hold_run = 1;
                hold_len = 1;
            end
        end
    endtask

    initial begin
        int v;
        rst          = 1'b0;
        fifo_rd_data = 8'h00;
        spi_busy     = 1'b0;
        spi_done     = 1'b0;
        spi_data     = 8'h00;
        pause        = 1'b0;
        fork
            monitor();
        join_none

        tick(3);
        check("reset_outputs", {7'd0, fifo_rd_en, spi_start, disp_valid, err_timeout, busy,
                                spi_addr, disp_data, rd_count}, 32'd0);
        rst = 1'b1;

        // Single read.
        resp_delay = 1;
        push(8'h12);
        wait_valid(1, 100, "single_valid");
        tick(8);
        check("single_pops", 32'(pop_cnt), 32'd1);
        check("single_addr", {24'd0, spi_addr}, 32'h12);
        check("single_count", {24'd0, rd_count}, 32'd1);
        check("single_idle", 32'(busy), 32'd0);
        resp_delay = -1;

        // Engine busy through LAUNCH.
        spi_busy = 1'b1;
        push(8'($urandom));
        tick(13);
        check("no_start_while_busy", 32'(start_cnt), 32'd1);
        spi_busy = 1'b0;
        wait_valid(2, 100, "busy_valid");
        check("busy_one_start", 32'(start_cnt), 32'd2);

        // Pause in IDLE blocks pops.
        tick(8);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) push(8'($urandom));
        tick(30);
        check("pause_no_pop", 32'(pop_cnt), 32'd2);
        pause = 1'b0;
        wait_valid(5, 200, "pause_drain");

        // Pause raised mid-WAIT lets the transaction finish, then holds IDLE.
        tick(8);
        resp_delay = 8;
        push(8'($urandom));
        push(8'($urandom));
        wait_start(6, 100, "pwait_start");
        pause = 1'b1;
        wait_valid(6, 100, "pwait_valid");
        tick(20);
        check("pwait_one_pop", 32'(pop_cnt), 32'd6);
        check("pwait_idle", 32'(busy), 32'd0);
        pause = 1'b0;
        wait_valid(7, 100, "pwait_resume");
        resp_delay = -1;

        // Randomized traffic with a flickering busy engine.
        for (int i = 0; i < 40; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(1, 12)) begin
                spi_busy = ($urandom_range(0, 3) == 0);
                tick(1);
            end
        end
        spi_busy = 1'b0;
        wait_valid(47, 2000, "random_drain");
        tick(8);

        // Engine never answers.
        resp_mode = 1;
        v = valid_cnt;
        push(8'($urandom));
`ifdef SCHED_TIMEOUT_EN
        wait_valid(v + 1, 100, "timeout_valid");
        check("timeout_flag", 32'(err_timeout), 32'd1);
        check("timeout_data", {24'd0, disp_data}, 32'h3F);
        tick(8);
        resp_mode  = 0;
        resp_delay = Tmo - 1;
        push(8'($urandom));
        wait_valid(v + 2, 100, "late_done_valid");
        resp_delay = -1;
`else
        wait_start(start_cnt + 1, 100, "nowd_start");
        tick(100);
        check("nowd_no_flag", 32'(err_timeout), 32'd0);
        check("nowd_still_busy", 32'(busy), 32'd1);
        check("nowd_no_valid", 32'(valid_cnt), 32'(v));
        resp_mode = 0;
        pend      = 1;
        cnt       = 0;
        wait_valid(v + 1, 100, "nowd_done_valid");
`endif
        tick(8);

        // Reset in the middle of WAIT, then a stray completion.
        resp_mode = 1;
        v = start_cnt;
        push(8'($urandom));
        wait_start(v + 1, 100, "rst_start");
        tick(3);
        rst = 1'b0;
        #1;
        check("rst_async_outputs", {7'd0, fifo_rd_en, spi_start, disp_valid, err_timeout, busy,
                                    spi_addr, disp_data, rd_count}, 32'd0);
        clear_model();
        tick(2);
        rst       = 1'b1;
        resp_mode = 0;
        v = valid_cnt;
        tick(2);
        spi_data = 8'h77;
        spi_done = 1'b1;
        tick(1);
        spi_done = 1'b0;
        tick(6);
        check("stray_done_ignored", {busy, disp_valid, err_timeout, 5'd0, disp_data, rd_count},
              16'd0);
        check("stray_no_valid", 32'(valid_cnt), 32'(v));

        // Back-to-back 257 reads from reset: counter wraps to 1.
        for (int i = 0; i < 257; i++) push(8'($urandom));
        wait_valid(v + 257, 6000, "b2b_valid");
        tick(10);
        check("b2b_pops", 32'(pop_cnt), 32'd257);
        check("b2b_wrap", {24'd0, rd_count}, 32'd1);
        check("b2b_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flash_read_scheduler.md
FLASH_READ_SCHEDULER -- requirements
Module: flash_read_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- HOLD_CYCLES, 1000: clocks each result is held before the next fetch.
- TIMEOUT_CYCLES, 4096: WAIT watchdog limit.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single system clock.
- rst, in, 1: asynchronous active-low reset.
- fifo_empty, in, 1: address FIFO empty.
- fifo_rd_en, out, 1: FIFO pop strobe; data is valid the next cycle.
- fifo_rd_data, in, 8: popped address offset.
- spi_busy, in, 1: SPI read engine busy.
- spi_start, out, 1: one-cycle start pulse.
- spi_addr, out, 8: address offset for the SPI engine.
- spi_done, in, 1: one-cycle completion pulse.
- spi_data, in, 8: byte read, valid with spi_done.
- pause, in, 1: suppresses new fetches.
- disp_data, out, 8: byte presented to the display decoder.
- disp_valid, out, 1: one-cycle pulse when disp_data updates.
- busy, out, 1: high in any state except IDLE.
- rd_count, out, 8: completed reads, wrapping.
- err_timeout, out, 1: sticky watchdog flag.

Function
REQ-003 FSM states SHALL be IDLE, POP, FETCH, LAUNCH, WAIT, HOLD; all outputs are registered.
REQ-004 IDLE -> POP SHALL occur when fifo_empty=0 and pause=0; otherwise the FSM stays in IDLE.
REQ-005 POP SHALL drive fifo_rd_en=1 for exactly one cycle, then go to FETCH.
REQ-006 FETCH SHALL latch fifo_rd_data into spi_addr, then go to LAUNCH.
REQ-007 LAUNCH SHALL wait while spi_busy=1; on the first cycle spi_busy=0, it SHALL pulse spi_start=1 for one cycle and go to WAIT.
REQ-008 spi_addr SHALL stay stable from FETCH until the next FETCH.
REQ-009 In WAIT, spi_done=1 SHALL:
- latch spi_data into disp_data;
- pulse disp_valid the following cycle;
- increment rd_count (255 wraps to 0);
- go to HOLD.
REQ-010 HOLD SHALL last exactly HOLD_CYCLES clocks, then return to IDLE; HOLD_CYCLES=0 is treated as 1.
REQ-011 Minimum latency from IDLE exit to spi_start SHALL be 3 cycles (POP, FETCH, LAUNCH).
REQ-012 pause SHALL be sampled only in IDLE; an in-flight transaction always completes.
REQ-013 At most one fifo_rd_en SHALL be issued per transaction; no pop occurs while fifo_empty=1.
REQ-014 spi_done outside WAIT SHALL be ignored, with no output change.
REQ-015 fifo_empty asserting after POP SHALL NOT abort the transaction.

Reset
REQ-016 rst=0 SHALL asynchronously force the following, and abort any in-flight transaction without issuing a pulse:
- state = IDLE;
- fifo_rd_en, spi_start, disp_valid, err_timeout = 0;
- spi_addr, disp_data, rd_count = 0;
- HOLD and watchdog counters = 0.
REQ-017 The first fetch after reset deassertion SHALL occur no earlier than the first rising edge with rst=1.

Configuration
REQ-018 Macro SCHED_TIMEOUT_EN SHALL compile the WAIT watchdog in or out.
REQ-019 With SCHED_TIMEOUT_EN defined, if WAIT lasts TIMEOUT_CYCLES clocks without spi_done:
- err_timeout SHALL set (sticky until reset);
- disp_data SHALL become 8'h3F;
- disp_valid SHALL pulse;
- rd_count SHALL NOT increment;
- the FSM SHALL go to HOLD.
REQ-020 With SCHED_TIMEOUT_EN defined, spi_done arriving on the timeout cycle SHALL win and be treated as a normal completion.
REQ-021 Without SCHED_TIMEOUT_EN, WAIT SHALL be unbounded and err_timeout tied to 0.

Verification
REQ-022 Single read (HOLD_CYCLES=4): FIFO holds 8'h12, spi_done with spi_data=8'h41 two cycles after spi_start -> one fifo_rd_en, spi_addr=8'h12, disp_data=8'h41, one disp_valid, rd_count=1, return to IDLE after 4 HOLD clocks.
REQ-023 Busy engine: spi_busy=1 for 10 cycles in LAUNCH -> spi_start issued on the first cycle spi_busy=0, exactly once.
REQ-024 Pause: pause=1 with FIFO non-empty -> no fifo_rd_en; pause=1 raised during WAIT -> transaction completes, then the FSM stays in IDLE.
REQ-025 Back-to-back with wrap: 257 entries -> 257 disp_valid pulses, rd_count=1, no pop while fifo_empty=1.
REQ-026 Timeout (macro defined, TIMEOUT_CYCLES=16): no spi_done -> err_timeout=1 and disp_data=8'h3F after 16 WAIT clocks; done on the 16th clock -> normal completion.
REQ-027 Reset mid-WAIT: rst=0 -> all outputs zero immediately; a later stray spi_done is ignored.
